// File: rtl/fixmul_seq_pkg.sv
// Shared types and constants for the sequential signed fixed-point multiplier
// and the parent that wires its product into the downstream shifter.
package fixmul_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_SIGN = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // Shifter control used by the parent: right, arithmetic rescale of P.
  localparam logic SHIFT_LEFT    = 1'b0;
  localparam logic SHIFT_LOGICAL = 1'b0;

  function automatic int prod_width(input int n);
    return 2 * n;
  endfunction

endpackage

// File: rtl/fixmul_seq.sv
// Sequential signed N x N multiplier: sign-magnitude shift-and-add over N
// cycles, full 2N-bit product with a one-cycle DONE pulse.
module fixmul_seq
  import fixmul_seq_pkg::*;
#(
  parameter int N    = 8,
  parameter int FRAC = 4
) (
  input  logic                       CLK,
  input  logic                       RST_N,
  input  logic                       START,
  input  logic [N-1:0]               A,
  input  logic [N-1:0]               B,
  output logic                       BUSY,
  output logic                       DONE,
  output logic [prod_width(N)-1:0]   P,
  output logic [4:0]                 SHAMT,
  output state_e                     STATE_DBG
);

  localparam int PW = prod_width(N);
  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] LAST_STEP = CW'(N - 1);

  // Handshake: START is accepted on a rising edge only while BUSY=0
  // (IDLE or DONE state); requests while BUSY=1 are dropped, not queued.

  state_e          state_q;
  logic [PW-1:0]   mcand_q;
  logic [N-1:0]    mplier_q;
  logic [PW-1:0]   acc_q;
  logic [CW-1:0]   cnt_q;
  logic            neg_q;
  logic            busy_q;
  logic            done_q;
  logic [PW-1:0]   p_q;

  logic            accept;
  logic [N-1:0]    mag_a_d;
  logic [N-1:0]    mag_b_d;
  logic [PW-1:0]   acc_d;

  // -(-2^(N-1)) wraps to 2^(N-1), which is exactly right as an unsigned value.
  assign mag_a_d = A[N-1] ? (~A + 1'b1) : A;
  assign mag_b_d = B[N-1] ? (~B + 1'b1) : B;
  assign acc_d   = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
  assign accept  = START && ((state_q == ST_IDLE) || (state_q == ST_DONE));

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= ST_IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      p_q      <= '0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          done_q <= 1'b0;
          if (accept) begin
            mcand_q  <= {{N{1'b0}}, mag_a_d};
            mplier_q <= mag_b_d;
            neg_q    <= A[N-1] ^ B[N-1];
            acc_q    <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b1;
            state_q  <= ST_RUN;
          end else begin
            state_q  <= ST_IDLE;
          end
        end
        ST_RUN: begin
          // The multiplicand is kept pre-shifted by the step count.
          acc_q    <= acc_d;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + 1'b1;
          if (cnt_q == LAST_STEP) state_q <= ST_SIGN;
        end
        ST_SIGN: begin
          p_q     <= neg_q ? (~acc_q + 1'b1) : acc_q;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= ST_DONE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign BUSY      = busy_q;
  assign DONE      = done_q;
  assign P         = p_q;
  assign SHAMT     = 5'(FRAC);
  assign STATE_DBG = state_q;

endmodule

// File: tb/tb_fixmul_seq.sv
// Self-checking bench for fixmul_seq (N=8, FRAC=4): scoreboard of expected
// products and accept cycles, checked when DONE pulses.
module tb_fixmul_seq;
  import fixmul_seq_pkg::*;

  localparam int N  = 8;
  localparam int PW = 16;

  logic          CLK;
  logic          RST_N;
  logic          START;
  logic [N-1:0]  A;
  logic [N-1:0]  B;
  logic          BUSY;
  logic          DONE;
  logic [PW-1:0] P;
  logic [4:0]    SHAMT;
  state_e        STATE_DBG;

  fixmul_seq #(.N(N), .FRAC(4)) dut (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .START    (START),
    .A        (A),
    .B        (B),
    .BUSY     (BUSY),
    .DONE     (DONE),
    .P        (P),
    .SHAMT    (SHAMT),
    .STATE_DBG(STATE_DBG)
  );

  // ---------------- clock / reset ----------------
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // ---------------- scoreboard ----------------
  logic [PW-1:0] exp_q[$];
  int            lat_q[$];
  int            n_checks = 0;
  int            n_pass   = 0;
  int            done_cnt = 0;
  int            last_done_cyc = 0;
  int            prev_done_cyc = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic logic [PW-1:0] model(input logic [N-1:0] a, input logic [N-1:0] b);
    int sa, sb;
    sa = int'($signed(a));
    sb = int'($signed(b));
    return PW'(sa * sb);
  endfunction

  always @(negedge CLK) begin
    if (RST_N && DONE) begin
      logic [PW-1:0] e;
      int            c;
      done_cnt++;
      prev_done_cyc = last_done_cyc;
      last_done_cyc = cyc;
      if (exp_q.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        c = lat_q.pop_front();
        check("product", 32'(P), 32'(e));
        check("latency", 32'(cyc - c), 32'd9);
        check("shamt", 32'(SHAMT), 32'd4);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_mul(input logic [N-1:0] a, input logic [N-1:0] b);
    @(negedge CLK);
    A = a; B = b; START = 1'b1;
    @(posedge CLK);
    #1;
    lat_q.push_back(cyc);
    exp_q.push_back(model(a, b));
    START = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || BUSY) && n < 60) begin
      @(negedge CLK);
      n++;
    end
    if (exp_q.size() != 0 || BUSY) begin
      check("timeout", 32'd1, 32'd0);
      exp_q.delete();
      lat_q.delete();
    end
    @(negedge CLK);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int bc, d0, gap;
    RST_N = 1'b0; START = 1'b0; A = '0; B = '0;
    #2;
    check("rst_busy", 32'(BUSY), 32'd0);
    check("rst_done", 32'(DONE), 32'd0);
    check("rst_p", 32'(P), 32'd0);
    check("rst_shamt", 32'(SHAMT), 32'd4);
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;

    // Basic product with BUSY width measurement.
    do_mul(8'd3, 8'd5);
    bc = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      if (BUSY) bc++;
      else break;
    end
    check("busy_width", 32'(bc), 32'd9);
    wait_idle();
    check("p_3x5", 32'(P), 32'h000F);

    // Signs and extremes.
    do_mul(8'hFD, 8'd5);   wait_idle();
    check("p_m3x5", 32'(P), 32'hFFF1);
    do_mul(8'hFD, 8'hFB);  wait_idle();
    do_mul(8'h80, 8'h80);  wait_idle();
    check("p_m128sq", 32'(P), 32'h4000);
    do_mul(8'h80, 8'h7F);  wait_idle();
    check("p_m128x127", 32'(P), 32'hC080);
    do_mul(8'h00, 8'hFF);  wait_idle();

    // Random pairs.
    for (int i = 0; i < 8; i++) begin
      do_mul(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
      wait_idle();
    end

    // START re-pulsed during RUN is ignored.
    d0 = done_cnt;
    do_mul(8'd3, 8'd5);
    repeat (3) @(negedge CLK);
    A = 8'd7; B = 8'd9; START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    wait_idle();
    repeat (5) @(negedge CLK);
    check("ignored_start_dones", 32'(done_cnt - d0), 32'd1);
    check("ignored_start_p", 32'(P), 32'h000F);

    // START held in the DONE cycle: back-to-back products.
    do_mul(8'd3, 8'd5);
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      if (DONE) break;
    end
    A = 8'd2; B = 8'd2; START = 1'b1;
    @(posedge CLK);
    #1;
    lat_q.push_back(cyc);
    exp_q.push_back(model(8'd2, 8'd2));
    START = 1'b0;
    wait_idle();
    gap = last_done_cyc - prev_done_cyc;
    check("b2b_gap", 32'(gap), 32'd10);
    check("b2b_p", 32'(P), 32'd4);

    // Asynchronous reset during RUN step 4 aborts the product.
    do_mul(8'd3, 8'd5);
    repeat (4) @(posedge CLK);
    @(negedge CLK);
    RST_N = 1'b0;
    #1;
    check("arst_busy", 32'(BUSY), 32'd0);
    check("arst_done", 32'(DONE), 32'd0);
    check("arst_p", 32'(P), 32'd0);
    exp_q.delete();
    lat_q.delete();
    d0 = done_cnt;
    @(negedge CLK);
    RST_N = 1'b1;
    repeat (15) @(negedge CLK);
    check("arst_no_done", 32'(done_cnt - d0), 32'd0);
    check("arst_p_after", 32'(P), 32'd0);
    do_mul(8'hF9, 8'd6);
    wait_idle();
    check("post_rst_dones", 32'(done_cnt - d0), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fixmul_seq.md
# fixmul_seq

Sequential signed fixed-point multiplier for the Mandelbrot iteration datapath. It accepts two N-bit two's-complement operands, forms the full 2N-bit product with a shift-and-add loop over N cycles, and presents it with a one-cycle DONE pulse. Its product feeds the downstream `shifter` directly: the parent wires P to the shifter's IN and drives the shifter's right-arithmetic rescale using the SHAMT output (value FRAC, left=0, logical=0).

## Interface

- N, 8: operand width in bits; legal range 2–16.
- FRAC, 4: fractional bits per operand; emitted on SHAMT so the shifter renormalises the product; 0 ≤ FRAC < N.

- CLK  input  1  clock; all state updates on the rising edge.
- RST_N  input  1  reset, asynchronous assert, active-low.
- START  input  1  request; sampled only while BUSY=0.
- A  input  N  multiplicand, signed; captured on the accepting edge.
- B  input  N  multiplier, signed; captured on the accepting edge.
- BUSY  output  1  high while a product is in progress (RUN, SIGN).
- DONE  output  1  one-cycle pulse; P is valid and newly written.
- P  output  2N  signed full product A*B; holds until the next product is written.
- SHAMT  output  5  constant FRAC; tied to the downstream shifter's shamt input.

## Operation

- States: IDLE, RUN, SIGN, DONE.
- IDLE: when START=1, capture |A| and |B| as N-bit unsigned values, capture neg = A[N-1]^B[N-1], clear the accumulator and counter, go to RUN. When START=0, stay in IDLE.
- RUN: each cycle, if multiplier LSB=1, add the multiplicand (shifted left by counter) into the 2N-bit unsigned accumulator; shift the multiplier right by one; increment the counter. After the N-th step go to SIGN.
- SIGN: P <= neg ? -acc : acc (2N-bit two's complement); DONE <= 1; go to DONE.
- DONE: DONE <= 0. If START=1, accept the new operands exactly as in IDLE and go to RUN; otherwise go to IDLE.
- Magnitude of -2^(N-1) is 2^(N-1), which fits the N-bit unsigned register. The largest magnitude product is 2^(2N-2), so it always fits in 2N signed bits. No overflow is possible.
- START while BUSY=1 is ignored and is not queued; operands are not re-sampled.
- A zero operand still takes the full N steps. The latency does not depend on the data.

## Timing

- Reset (RST_N=0, asynchronous): state=IDLE, BUSY=0, DONE=0, P=0, accumulator and counter cleared.
- SHAMT is always FRAC, including during reset.
- Reset asserted mid-operation aborts the product. No DONE is issued. P reads 0 after release.
- An accepting edge at k gives:
  - RUN steps at edges k+1..k+N.
  - P written and DONE=1 at edge k+N+1.
  - DONE=0 at edge k+N+2.
- Latency from the accepting edge to DONE high is N+1 cycles.
- BUSY is high from edge k to edge k+N+1 (it drops as DONE rises).
- Back-to-back throughput is one product per N+2 cycles when START is held in the DONE cycle.
- P changes only at the SIGN→DONE edge and at reset.

## Structure

- Shared package holds:
  - the state enum {IDLE, RUN, SIGN, DONE};
  - the product width constant 2N;
  - the shifter control constants (LEFT=0, LOGICAL=0) used by the parent when wiring P into the shifter.
- No sub-module. Magnitude, negation and the add-shift step are inline.
- The downstream shifter is instantiated by the parent, not inside this block.

## Test plan

All scenarios use N=8, FRAC=4.

- A=3, B=5, START one cycle:
  - DONE high exactly 9 cycles after the accepting edge.
  - P=16'h000F.
  - BUSY high for 9 cycles.
- A=-3, B=5 → P=16'hFFF1. A=-3, B=-5 → P=16'h000F.
- Extremes:
  - A=-128, B=-128 → P=16'h4000.
  - A=-128, B=127 → P=16'hC080.
  - A=0, B=-1 → P=0, with the same 9-cycle latency.
- START re-pulsed with different operands during RUN: ignored; P equals the first pair's product; exactly one DONE pulse.
- START held in the DONE cycle with A=2, B=2 after A=3, B=5:
  - second DONE follows 10 cycles after the first;
  - P=15 then 4.
- RST_N pulsed low for one cycle during RUN step 4:
  - BUSY and DONE go low immediately (asynchronous) and P=0;
  - no DONE is issued;
  - the next START completes normally.
